// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: data_memory size encoding,
// FSM state encoding, latency-counter width and small decode helpers.
// Optional feature macro: MISALIGN_TRAP_EN (adds the TRAP state).
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Wide enough to count READ_LATENCY values 1..4
    localparam int LAT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3
`ifdef MISALIGN_TRAP_EN
        , ST_TRAP = 3'd4
`endif
    } lsu_state_t;

    // The unused encoding 2'b10 behaves as a word access
    function automatic logic [1:0] normSize(input logic [1:0] size);
        if (size == SIZE_BYTE)      return SIZE_BYTE;
        else if (size == SIZE_HALF) return SIZE_HALF;
        else                        return SIZE_WORD;
    endfunction

    // Expects an already normalised size; bytes can never misalign
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        if (size == SIZE_HALF)      return offset[0];
        else if (size == SIZE_WORD) return (offset != 2'b00);
        else                        return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction for a big-endian memory word (byte 0 = bits [31:24])
// followed by sign or zero extension. Purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signBit;

    // Pick the addressed byte/half lane and extend it to 32 bits
    always_comb begin
        w_byte    = i_rdata[7:0];
        w_half    = i_rdata[15:0];
        w_signBit = 1'b0;
        o_data    = i_rdata;
        case (i_offset)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];
        case (i_size)
            SIZE_BYTE: begin
                w_signBit = ~i_unsigned & w_byte[7];
                o_data    = {{24{w_signBit}}, w_byte};
            end
            SIZE_HALF: begin
                w_signBit = ~i_unsigned & w_half[15];
                o_data    = {{16{w_signBit}}, w_half};
            end
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit between the ALU result path and data_memory.
// Accepts one request per handshake, issues one-cycle memory strobes, waits
// READ_LATENCY cycles (1..4) for read data and returns the extended result.
// Optional feature macro: MISALIGN_TRAP_EN -- misaligned requests trap
// instead of having their low address bits cleared.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_load,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [4:0]        i_req_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [1:0]        o_mem_size,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_data,
    output logic [4:0]        o_resp_rd,
    output logic              o_busy,
    output logic              o_exc_valid,
    output logic [ADDR_W-1:0] o_exc_addr
);

    // Counter value reached in the final WAIT cycle, when read data is valid
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LATENCY - 1);

    lsu_state_t           r_state;
    logic [LAT_CNT_W-1:0] r_latCnt;
    logic                 r_load;
    logic                 r_unsigned;
    logic [4:0]           r_rd;
    logic [ADDR_W-1:0]    r_memAddr;
    logic [31:0]          r_memWdata;
    logic [1:0]           r_memSize;
    logic                 r_memRe;
    logic                 r_memWe;
    logic                 r_respValid;
    logic [31:0]          r_respData;
    logic [4:0]           r_respRd;
    logic                 r_busy;

    logic                 w_accept;
    logic [1:0]           w_size;
    logic [ADDR_W-1:0]    w_reqAddr;
    logic [31:0]          w_storeData;
    logic [31:0]          w_loadData;

    assign w_accept = i_req_valid && (r_state == ST_IDLE);
    assign w_size   = normSize(i_req_size);

`ifdef MISALIGN_TRAP_EN
    logic              w_misaligned;
    logic              r_excValid;
    logic [ADDR_W-1:0] r_excAddr;

    // Misaligned requests never reach memory, so the address passes untouched
    assign w_reqAddr    = i_req_addr;
    assign w_misaligned = isMisaligned(w_size, i_req_addr[1:0]);
    assign o_exc_valid  = r_excValid;
    assign o_exc_addr   = r_excAddr;
`else
    // Silently align half/word accesses by clearing the offending low bits
    always_comb begin
        w_reqAddr = i_req_addr;
        if (w_size == SIZE_HALF)
            w_reqAddr[0] = 1'b0;
        else if (w_size == SIZE_WORD)
            w_reqAddr[1:0] = 2'b00;
    end

    assign o_exc_valid = 1'b0;
    assign o_exc_addr  = '0;
`endif

    // Replicate store data across every lane the access size can hit
    always_comb begin
        case (w_size)
            SIZE_BYTE: w_storeData = {4{i_req_wdata[7:0]}};
            SIZE_HALF: w_storeData = {2{i_req_wdata[15:0]}};
            default:   w_storeData = i_req_wdata;
        endcase
    end

    lsu_load_align u_align (
        .i_rdata    (i_mem_rdata),
        .i_offset   (r_memAddr[1:0]),
        .i_size     (r_memSize),
        .i_unsigned (r_unsigned),
        .o_data     (w_loadData)
    );

    // Request sequencing: accept, strobe memory, wait out latency, respond
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_latCnt    <= '0;
            r_load      <= 1'b0;
            r_unsigned  <= 1'b0;
            r_rd        <= '0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_memSize   <= SIZE_BYTE;
            r_memRe     <= 1'b0;
            r_memWe     <= 1'b0;
            r_respValid <= 1'b0;
            r_respData  <= '0;
            r_respRd    <= '0;
            r_busy      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_excValid  <= 1'b0;
            r_excAddr   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_load     <= i_req_load;
                        r_unsigned <= i_req_unsigned;
                        r_rd       <= i_req_rd;
                        r_busy     <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_state    <= ST_TRAP;
                            r_excValid <= 1'b1;
                            r_excAddr  <= i_req_addr;
                        end else
`endif
                        begin
                            r_state    <= ST_ACCESS;
                            r_memAddr  <= w_reqAddr;
                            r_memWdata <= w_storeData;
                            r_memSize  <= w_size;
                            r_memRe    <= i_req_load;
                            r_memWe    <= ~i_req_load;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_memRe  <= 1'b0;
                    r_memWe  <= 1'b0;
                    r_latCnt <= '0;
                    if (r_load) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_latCnt == LAT_LAST) begin
                        r_respData  <= w_loadData;
                        r_respRd    <= r_rd;
                        r_respValid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_latCnt <= r_latCnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_respValid <= 1'b0;
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                end
`ifdef MISALIGN_TRAP_EN
                ST_TRAP: begin
                    r_excValid <= 1'b0;
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                end
`endif
                default: begin
                    r_state     <= ST_IDLE;
                    r_memRe     <= 1'b0;
                    r_memWe     <= 1'b0;
                    r_respValid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_mem_addr   = r_memAddr;
    assign o_mem_wdata  = r_memWdata;
    assign o_mem_re     = r_memRe;
    assign o_mem_we     = r_memWe;
    assign o_mem_size   = r_memSize;
    assign o_resp_valid = r_respValid;
    assign o_resp_data  = r_respData;
    assign o_resp_rd    = r_respRd;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a READ_LATENCY=1 instance driven from a vector
// table, and a READ_LATENCY=3 instance for latency and reset-abort sequences.
// Expectations follow MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit;

    typedef struct {
        logic        load;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] word;
        logic [31:0] expMemAddr;
        logic [1:0]  expMemSize;
        logic [31:0] expMemWdata;
        logic [31:0] expData;
        int          trap;
        int          expRe;
        int          expWe;
        int          expResp;
        int          expReady;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Signals of the READ_LATENCY=1 instance
    logic        reset = 1'b1;
    logic        reqValid = 1'b0, reqLoad = 1'b0, reqUnsigned = 1'b0;
    logic [1:0]  reqSize = 2'b00;
    logic [31:0] reqAddr = '0, reqWdata = '0;
    logic [4:0]  reqRd = '0;
    logic        reqReady, memRe, memWe, respValid, busy, excValid;
    logic [31:0] memAddr, memWdata, memRdata, respData, excAddr;
    logic [1:0]  memSize;
    logic [4:0]  respRd;

    // Signals of the READ_LATENCY=3 instance
    logic        reset3 = 1'b1;
    logic        reqValid3 = 1'b0, reqLoad3 = 1'b0, reqUnsigned3 = 1'b0;
    logic [1:0]  reqSize3 = 2'b00;
    logic [31:0] reqAddr3 = '0, reqWdata3 = '0;
    logic [4:0]  reqRd3 = '0;
    logic        reqReady3, memRe3, memWe3, respValid3, busy3, excValid3;
    logic [31:0] memAddr3, memWdata3, memRdata3, respData3, excAddr3;
    logic [1:0]  memSize3;
    logic [4:0]  respRd3;

    load_store_unit #(.READ_LATENCY(1), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_load(reqLoad),
        .i_req_size(reqSize), .i_req_unsigned(reqUnsigned), .i_req_addr(reqAddr),
        .i_req_wdata(reqWdata), .i_req_rd(reqRd),
        .o_mem_addr(memAddr), .o_mem_wdata(memWdata), .o_mem_re(memRe), .o_mem_we(memWe),
        .o_mem_size(memSize), .i_mem_rdata(memRdata),
        .o_resp_valid(respValid), .o_resp_data(respData), .o_resp_rd(respRd),
        .o_busy(busy), .o_exc_valid(excValid), .o_exc_addr(excAddr)
    );

    load_store_unit #(.READ_LATENCY(3), .ADDR_W(32)) dut3 (
        .clock(clock), .reset(reset3),
        .i_req_valid(reqValid3), .o_req_ready(reqReady3), .i_req_load(reqLoad3),
        .i_req_size(reqSize3), .i_req_unsigned(reqUnsigned3), .i_req_addr(reqAddr3),
        .i_req_wdata(reqWdata3), .i_req_rd(reqRd3),
        .o_mem_addr(memAddr3), .o_mem_wdata(memWdata3), .o_mem_re(memRe3), .o_mem_we(memWe3),
        .o_mem_size(memSize3), .i_mem_rdata(memRdata3),
        .o_resp_valid(respValid3), .o_resp_data(respData3), .o_resp_rd(respRd3),
        .o_busy(busy3), .o_exc_valid(excValid3), .o_exc_addr(excAddr3)
    );

    // Memory models: the word is valid only READ_LATENCY cycles after mem_re
    logic [31:0] memWord = 32'h81C2_E3F4;
    logic        rePipe1 = 1'b0;
    logic [2:0]  rePipe3 = 3'b000;
    always @(posedge clock) begin
        rePipe1 <= memRe;
        rePipe3 <= {rePipe3[1:0], memRe3};
    end
    assign memRdata  = rePipe1    ? memWord      : 32'hDEAD_BEEF;
    assign memRdata3 = rePipe3[2] ? 32'h81C2_E3F4 : 32'hDEAD_BEEF;

    // Observations of one transaction on the latency-1 instance
    int          resReadyStart, resBusy1, resRe, resWe, resRespCnt, resRespAt, resExcAt, resReadyAt;
    logic [31:0] resMemAddr, resMemWdata, resRespData, resExcAddr;
    logic [1:0]  resMemSize;
    logic [4:0]  resRespRd;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic load, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                                   input logic [31:0] word, input logic [31:0] eAddr, input logic [1:0] eSize,
                                   input logic [31:0] eWdata, input logic [31:0] eData, input int trap);
        vec_t v;
        v.load = load; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.word = word; v.expMemAddr = eAddr; v.expMemSize = eSize; v.expMemWdata = eWdata;
        v.expData = eData; v.trap = trap;
        v.expRe    = (load && trap == 0) ? 1 : 0;
        v.expWe    = (!load && trap == 0) ? 1 : 0;
        v.expResp  = (load && trap == 0) ? 3 : -1;
        v.expReady = (load && trap == 0) ? 4 : 2;
        return v;
    endfunction

    // Drive one request in the current cycle and watch the following 8 cycles
    task automatic applyStimulus(input vec_t v);
        memWord = v.word;
        resReadyStart = int'(reqReady);
        resRe = 0; resWe = 0; resRespCnt = 0; resRespAt = -1; resExcAt = -1; resReadyAt = -1;
        reqValid = 1'b1; reqLoad = v.load; reqSize = v.size; reqUnsigned = v.uns;
        reqAddr = v.addr; reqWdata = v.wdata; reqRd = v.rd;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                reqValid = 1'b0;
                resBusy1 = int'(busy);
                resMemAddr = memAddr; resMemWdata = memWdata; resMemSize = memSize;
            end
            if (memRe) resRe++;
            if (memWe) resWe++;
            if (respValid) begin
                resRespCnt++;
                if (resRespAt < 0) begin resRespAt = c; resRespData = respData; resRespRd = respRd; end
            end
            if (excValid && resExcAt < 0) begin resExcAt = c; resExcAddr = excAddr; end
            if (reqReady && resReadyAt < 0) resReadyAt = c;
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int secondAt, respCnt, reCnt, respAt3, readyAt3;
        logic [31:0] respData3Seen;

        // Loads on 0x81C2_E3F4 and other words, stores, then misaligned cases
        vecs.push_back(mkVec(1, 2'b00, 0, 32'h1000_0001, 0, 5'd5,  32'h81C2_E3F4, 32'h1000_0001, 2'b00, 0, 32'hFFFF_FFC2, 0));
        vecs.push_back(mkVec(1, 2'b00, 1, 32'h1000_0003, 0, 5'd6,  32'h81C2_E3F4, 32'h1000_0003, 2'b00, 0, 32'h0000_00F4, 0));
        vecs.push_back(mkVec(1, 2'b01, 0, 32'h1000_0002, 0, 5'd7,  32'h81C2_E3F4, 32'h1000_0002, 2'b01, 0, 32'hFFFF_E3F4, 0));
        vecs.push_back(mkVec(1, 2'b01, 1, 32'h1000_0000, 0, 5'd8,  32'h81C2_E3F4, 32'h1000_0000, 2'b01, 0, 32'h0000_81C2, 0));
        vecs.push_back(mkVec(1, 2'b11, 0, 32'h1000_0000, 0, 5'd17, 32'h81C2_E3F4, 32'h1000_0000, 2'b11, 0, 32'h81C2_E3F4, 0));
        vecs.push_back(mkVec(1, 2'b00, 0, 32'h2000_0000, 0, 5'd3,  32'h7F80_0102, 32'h2000_0000, 2'b00, 0, 32'h0000_007F, 0));
        vecs.push_back(mkVec(1, 2'b00, 0, 32'h2000_0001, 0, 5'd4,  32'h7F80_0102, 32'h2000_0001, 2'b00, 0, 32'hFFFF_FF80, 0));
        vecs.push_back(mkVec(1, 2'b01, 0, 32'h2000_0000, 0, 5'd9,  32'h7F80_0102, 32'h2000_0000, 2'b01, 0, 32'h0000_7F80, 0));
        vecs.push_back(mkVec(1, 2'b01, 0, 32'h2000_0002, 0, 5'd10, 32'h1234_8765, 32'h2000_0002, 2'b01, 0, 32'hFFFF_8765, 0));
        vecs.push_back(mkVec(1, 2'b00, 0, 32'h2000_0002, 0, 5'd11, 32'h1234_5678, 32'h2000_0002, 2'b00, 0, 32'h0000_0056, 0));
        vecs.push_back(mkVec(1, 2'b10, 0, 32'h1000_0008, 0, 5'd12, 32'h0BAD_F00D, 32'h1000_0008, 2'b11, 0, 32'h0BAD_F00D, 0));
        vecs.push_back(mkVec(0, 2'b00, 0, 32'h1000_0002, 32'h0000_00AB, 5'd1, 32'h81C2_E3F4, 32'h1000_0002, 2'b00, 32'hABAB_ABAB, 0, 0));
        vecs.push_back(mkVec(0, 2'b01, 0, 32'h1000_0000, 32'h1234_BEEF, 5'd1, 32'h81C2_E3F4, 32'h1000_0000, 2'b01, 32'hBEEF_BEEF, 0, 0));
        vecs.push_back(mkVec(0, 2'b11, 0, 32'h1000_0004, 32'hCAFE_F00D, 5'd1, 32'h81C2_E3F4, 32'h1000_0004, 2'b11, 32'hCAFE_F00D, 0, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mkVec(1, 2'b11, 0, 32'h1000_0006, 0, 5'd20, 32'h81C2_E3F4, 0, 2'b00, 0, 0, 1));
        vecs.push_back(mkVec(1, 2'b01, 0, 32'h1000_0003, 0, 5'd21, 32'h81C2_E3F4, 0, 2'b00, 0, 0, 1));
        vecs.push_back(mkVec(0, 2'b11, 0, 32'h1000_0001, 32'h1122_3344, 5'd1, 32'h81C2_E3F4, 0, 2'b00, 0, 0, 1));
        vecs.push_back(mkVec(1, 2'b01, 1, 32'h1000_0001, 0, 5'd22, 32'h81C2_E3F4, 0, 2'b00, 0, 0, 1));
`else
        vecs.push_back(mkVec(1, 2'b11, 0, 32'h1000_0006, 0, 5'd20, 32'h81C2_E3F4, 32'h1000_0004, 2'b11, 0, 32'h81C2_E3F4, 0));
        vecs.push_back(mkVec(1, 2'b01, 0, 32'h1000_0003, 0, 5'd21, 32'h81C2_E3F4, 32'h1000_0002, 2'b01, 0, 32'hFFFF_E3F4, 0));
        vecs.push_back(mkVec(0, 2'b11, 0, 32'h1000_0001, 32'h1122_3344, 5'd1, 32'h81C2_E3F4, 32'h1000_0000, 2'b11, 32'h1122_3344, 0, 0));
        vecs.push_back(mkVec(1, 2'b01, 1, 32'h1000_0001, 0, 5'd22, 32'h81C2_E3F4, 32'h1000_0000, 2'b01, 0, 32'h0000_81C2, 0));
`endif

        // Reset state of both instances
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        reset3 = 1'b0;
        checkOutput("rst req_ready",  32'(reqReady),  32'd1);
        checkOutput("rst busy",       32'(busy),      32'd0);
        checkOutput("rst mem_re",     32'(memRe),     32'd0);
        checkOutput("rst mem_we",     32'(memWe),     32'd0);
        checkOutput("rst resp_valid", 32'(respValid), 32'd0);
        checkOutput("rst exc_valid",  32'(excValid),  32'd0);
        checkOutput("rst mem_addr",   memAddr,        32'd0);
        checkOutput("rst mem_wdata",  memWdata,       32'd0);
        checkOutput("rst resp_data",  respData,       32'd0);
        checkOutput("rst resp_rd",    32'(respRd),    32'd0);
        checkOutput("rst exc_addr",   excAddr,        32'd0);
        checkOutput("rst3 req_ready", 32'(reqReady3), 32'd1);

        // Table-driven transactions on the latency-1 instance
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d ready_before", i), 32'(resReadyStart), 32'd1);
            checkOutput($sformatf("v%0d busy_t1", i),      32'(resBusy1),      32'd1);
            checkOutput($sformatf("v%0d re_pulses", i),    32'(resRe),         32'(vecs[i].expRe));
            checkOutput($sformatf("v%0d we_pulses", i),    32'(resWe),         32'(vecs[i].expWe));
            if (vecs[i].expRe != 0 || vecs[i].expWe != 0) begin
                checkOutput($sformatf("v%0d mem_addr", i), resMemAddr,        vecs[i].expMemAddr);
                checkOutput($sformatf("v%0d mem_size", i), 32'(resMemSize),   32'(vecs[i].expMemSize));
            end
            if (vecs[i].expWe != 0)
                checkOutput($sformatf("v%0d mem_wdata", i), resMemWdata, vecs[i].expMemWdata);
            checkOutput($sformatf("v%0d resp_pulses", i), 32'(resRespCnt), (vecs[i].expResp >= 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("v%0d resp_cycle", i),  32'(resRespAt),  32'(vecs[i].expResp));
            if (vecs[i].expResp >= 0) begin
                checkOutput($sformatf("v%0d resp_data", i), resRespData,     vecs[i].expData);
                checkOutput($sformatf("v%0d resp_rd", i),   32'(resRespRd),  32'(vecs[i].rd));
            end
            checkOutput($sformatf("v%0d exc_cycle", i), 32'(resExcAt), (vecs[i].trap != 0) ? 32'd1 : 32'hFFFF_FFFF);
            if (vecs[i].trap != 0)
                checkOutput($sformatf("v%0d exc_addr", i), resExcAddr, vecs[i].addr);
            checkOutput($sformatf("v%0d ready_cycle", i), 32'(resReadyAt), 32'(vecs[i].expReady));
        end

        // resp_data/resp_rd hold the last load result across a later store
        applyStimulus(vecs[4]);
        applyStimulus(vecs[11]);
        checkOutput("hold resp_data", respData,    32'h81C2_E3F4);
        checkOutput("hold resp_rd",   32'(respRd), 32'd17);

        // Back-to-back: req_valid held, second load accepted only after RESP
        memWord = 32'h81C2_E3F4;
        secondAt = -1; respCnt = 0; reCnt = 0;
        reqValid = 1'b1; reqLoad = 1'b1; reqSize = 2'b11; reqUnsigned = 1'b0;
        reqAddr = 32'h1000_0000; reqRd = 5'd2;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1;
            if (secondAt >= 0 && c > secondAt) reqValid = 1'b0;
            if (memRe) reCnt++;
            if (respValid) respCnt++;
            if (reqValid && reqReady && secondAt < 0) secondAt = c;
        end
        reqValid = 1'b0;
        checkOutput("b2b second_accept", 32'(secondAt), 32'd4);
        checkOutput("b2b re_pulses",     32'(reCnt),    32'd2);
        checkOutput("b2b resp_pulses",   32'(respCnt),  32'd2);

        // READ_LATENCY=3: response in T+5, ready again in T+6
        respAt3 = -1; readyAt3 = -1; respData3Seen = '0;
        reqValid3 = 1'b1; reqLoad3 = 1'b1; reqSize3 = 2'b11; reqUnsigned3 = 1'b0;
        reqAddr3 = 32'h1000_0000; reqRd3 = 5'd9;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clock); #1;
            if (c == 1) reqValid3 = 1'b0;
            if (respValid3 && respAt3 < 0) begin respAt3 = c; respData3Seen = respData3; end
            if (reqReady3 && readyAt3 < 0) readyAt3 = c;
        end
        checkOutput("lat3 resp_cycle",  32'(respAt3),  32'd5);
        checkOutput("lat3 resp_data",   respData3Seen, 32'h81C2_E3F4);
        checkOutput("lat3 ready_cycle", 32'(readyAt3), 32'd6);

        // READ_LATENCY=3: reset in T+2 aborts the load
        respCnt = 0;
        reqValid3 = 1'b1; reqRd3 = 5'd13;
        @(posedge clock); #1;
        reqValid3 = 1'b0;
        @(posedge clock); #1;
        reset3 = 1'b1;
        @(posedge clock); #1;
        reset3 = 1'b0;
        checkOutput("abort req_ready", 32'(reqReady3), 32'd1);
        checkOutput("abort busy",      32'(busy3),     32'd0);
        checkOutput("abort mem_re",    32'(memRe3),    32'd0);
        for (int c = 0; c < 8; c++) begin
            if (respValid3) respCnt++;
            @(posedge clock); #1;
        end
        checkOutput("abort resp_pulses", 32'(respCnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
